// File: rtl/demultiplexer_1_to_4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready on every side.
// Each output channel owns a one-entry holding register.
module demultiplexer_1_to_4_reg #(
   parameter int N_BITS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic [1:0]        selector_i,
   input  logic [N_BITS-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [N_BITS-1:0] data_0_o,
   output logic [N_BITS-1:0] data_1_o,
   output logic [N_BITS-1:0] data_2_o,
   output logic [N_BITS-1:0] data_3_o,
   output logic              valid_0_o,
   output logic              valid_1_o,
   output logic              valid_2_o,
   output logic              valid_3_o,
   input  logic              ready_0_i,
   input  logic              ready_1_i,
   input  logic              ready_2_i,
   input  logic              ready_3_i
);

   logic [N_BITS-1:0] r_data [4];
   logic [3:0]        r_valid;
   logic [3:0]        w_ready;
   logic [3:0]        w_load;
   logic [3:0]        w_xfer;
   logic              w_accept;

   assign w_ready = {ready_3_i, ready_2_i, ready_1_i, ready_0_i};

   // A channel can take a word if empty or if its consumer drains it now
   always_comb begin
      ready_o  = !clear_i &
                 (!r_valid[selector_i] | w_ready[selector_i]);
      w_accept = valid_i & ready_o;
      w_load   = '0;
      w_xfer   = r_valid & w_ready;
      if (w_accept) begin
         w_load[selector_i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         for (int k = 0; k < 4; k++) begin
            r_data[k] <= '0;
         end
      end else if (clear_i) begin
         r_valid <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (w_load[k]) begin
               r_valid[k] <= 1'b1;
               r_data[k]  <= data_i;
            end else if (w_xfer[k]) begin
               r_valid[k] <= 1'b0;
            end
         end
      end
   end

   assign data_0_o  = r_data[0];
   assign data_1_o  = r_data[1];
   assign data_2_o  = r_data[2];
   assign data_3_o  = r_data[3];
   assign valid_0_o = r_valid[0];
   assign valid_1_o = r_valid[1];
   assign valid_2_o = r_valid[2];
   assign valid_3_o = r_valid[3];

endmodule

// File: tb/tb_demultiplexer_1_to_4_reg.sv
// Bench for demultiplexer_1_to_4_reg: directed scenarios, then random
// traffic checked against a per-channel one-slot queue model.
module tb_demultiplexer_1_to_4_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear_i;
   logic [1:0]  selector_i;
   logic [31:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] data_0_o, data_1_o, data_2_o, data_3_o;
   logic        valid_0_o, valid_1_o, valid_2_o, valid_3_o;
   logic [3:0]  rdy;

   logic [31:0] dout [4];
   logic [3:0]  vout;

   int tests = 0;
   int fails = 0;

   logic [31:0] mq [4][$];

   always #5 clk = ~clk;

   demultiplexer_1_to_4_reg #(.N_BITS(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (clear_i),
      .selector_i (selector_i),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .data_0_o   (data_0_o),
      .data_1_o   (data_1_o),
      .data_2_o   (data_2_o),
      .data_3_o   (data_3_o),
      .valid_0_o  (valid_0_o),
      .valid_1_o  (valid_1_o),
      .valid_2_o  (valid_2_o),
      .valid_3_o  (valid_3_o),
      .ready_0_i  (rdy[0]),
      .ready_1_i  (rdy[1]),
      .ready_2_i  (rdy[2]),
      .ready_3_i  (rdy[3])
   );

   assign dout[0] = data_0_o;
   assign dout[1] = data_1_o;
   assign dout[2] = data_2_o;
   assign dout[3] = data_3_o;
   assign vout    = {valid_3_o, valid_2_o, valid_1_o, valid_0_o};

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("valid_%0d", k), {31'd0, vout[k]},
             {31'd0, mq[k].size() != 0});
         if (mq[k].size() != 0) begin
            chk($sformatf("data_%0d", k), dout[k], mq[k][0]);
         end
      end
   endtask

   // One cycle: drive at negedge, check ready_o, clock, update model, check.
   task automatic step(input bit v, input bit [1:0] s,
                       input logic [31:0] d, input bit [3:0] r,
                       input bit c);
      bit exp_rdy;
      @(negedge clk);
      valid_i    = v;
      selector_i = s;
      data_i     = d;
      rdy        = r;
      clear_i    = c;
      #1;
      exp_rdy = !c && (mq[s].size() == 0 || r[s]);
      chk("ready_o", {31'd0, ready_o}, {31'd0, exp_rdy});
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         if (r[k] && mq[k].size() != 0) void'(mq[k].pop_front());
      end
      if (c) begin
         for (int k = 0; k < 4; k++) mq[k].delete();
      end else if (v && exp_rdy) begin
         mq[s].push_back(d);
      end
      #1;
      check_outs();
   endtask

   initial begin
      reset      = 1'b0;
      clear_i    = 1'b0;
      selector_i = 2'd0;
      data_i     = '0;
      valid_i    = 1'b0;
      rdy        = 4'hF;
      #12;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rst_valid_%0d", k), {31'd0, vout[k]}, 32'd0);
         chk($sformatf("rst_data_%0d", k), dout[k], 32'd0);
      end
      chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
      @(negedge clk);
      reset = 1'b1;

      // 1: single word to channel 2
      step(1, 2, 32'hA5A5_0001, 4'hF, 0);
      chk("t1_valid_2", {31'd0, valid_2_o}, 32'd1);
      chk("t1_data_2", data_2_o, 32'hA5A5_0001);
      chk("t1_others", {28'd0, vout & 4'b1011}, 32'd0);
      step(0, 0, 0, 4'hF, 0);

      // 2: stalled channel 1 blocks a second word to it
      step(1, 1, 32'h11, 4'b1101, 0);
      step(1, 1, 32'h22, 4'b1101, 0);
      chk("t2_data_1_hold", data_1_o, 32'h11);
      step(1, 1, 32'h22, 4'b1111, 0);
      chk("t2_data_1_new", data_1_o, 32'h22);
      step(0, 0, 0, 4'hF, 0);

      // 3: ch1 stalled full; other channels still flow
      step(1, 1, 32'h40, 4'b1101, 0);
      step(1, 0, 32'h30, 4'b1101, 0);
      step(1, 2, 32'h31, 4'b1101, 0);
      step(1, 3, 32'h32, 4'b1101, 0);
      step(1, 0, 32'h33, 4'b1101, 0);
      chk("t3_data_1", data_1_o, 32'h40);
      step(0, 0, 0, 4'hF, 0);

      // 4: full-rate stream on channel 0
      for (int i = 0; i < 16; i++) begin
         step(1, 0, i, 4'hF, 0);
         chk("t4_data_0", data_0_o, i);
      end
      step(0, 0, 0, 4'hF, 0);

      // 5: clear flushes ch0 and ch3 and rejects the input word
      step(1, 0, 32'h50, 4'h0, 0);
      step(1, 3, 32'h53, 4'h0, 0);
      step(1, 0, 32'h55, 4'h0, 1);
      chk("t5_valid_all", {28'd0, vout}, 32'd0);
      step(0, 0, 0, 4'h0, 0);

      // 6: asynchronous reset between edges
      step(1, 2, 32'hBEEF, 4'h0, 0);
      @(negedge clk);
      valid_i = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("t6_valid_2", {31'd0, valid_2_o}, 32'd0);
      chk("t6_data_2", data_2_o, 32'd0);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) mq[k].delete();
      for (int s = 0; s < 4; s++) begin
         selector_i = s[1:0];
         #1;
         chk($sformatf("t6_ready_sel%0d", s), {31'd0, ready_o}, 32'd1);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0,
              2'($urandom_range(0, 3)),
              $urandom,
              4'($urandom_range(0, 15)),
              $urandom_range(0, 15) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
